// File: rtl/tq_pkg.sv
// rtl/tq_pkg.sv - shared encodings, helpers and FIFO entry type for the tq row packer
package tq_pkg;

  localparam int TQ_IN_W  = 28;
  localparam int TQ_OUT_W = 16;
  localparam int TQ_LANES = 32;

  typedef enum logic [1:0] {
    TS_4  = 2'd0,
    TS_8  = 2'd1,
    TS_16 = 2'd2,
    TS_32 = 2'd3
  } tq_size_e;

  typedef struct packed {
    logic [TQ_LANES-1:0][TQ_OUT_W-1:0] lanes;
    logic                              first;
    logic                              last;
    logic [1:0]                        size;
    logic                              inverse;
  } tq_entry_t;

  function automatic logic [5:0] rows_per_block(input logic [1:0] transize);
    return 6'd4 << transize;
  endfunction

  function automatic logic [4:0] fwd_shift(input logic [1:0] transize);
    return {3'b000, transize} + 5'd1;
  endfunction

endpackage

// File: rtl/tq_round_sat.sv
// rtl/tq_round_sat.sv - one lane of round-half-up right shift followed by signed saturation
module tq_round_sat #(
  parameter int IN_W  = 28,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  x,
  input  logic        [4:0]       s,
  output logic signed [OUT_W-1:0] y
);

  localparam logic signed [IN_W:0] MAX_V = $signed({{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [IN_W:0] MIN_V = $signed({{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}});

  logic signed [IN_W:0] half;
  logic signed [IN_W:0] sum;
  logic signed [IN_W:0] shr;

  // One guard bit keeps x + half from wrapping at the positive limit.
  always_comb begin
    half = '0;
    if (s != 5'd0) begin
      half = $signed((IN_W+1)'(1) << (s - 5'd1));
    end
    sum = $signed({x[IN_W-1], x}) + half;
    shr = sum >>> s;
    if (shr > MAX_V) begin
      y = MAX_V[OUT_W-1:0];
    end else if (shr < MIN_V) begin
      y = MIN_V[OUT_W-1:0];
    end else begin
      y = shr[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/tq_stage3_rowpack.sv
// rtl/tq_stage3_rowpack.sv - rounds, saturates and frames stage-3 rows into a fall-through FIFO
module tq_stage3_rowpack
  import tq_pkg::*;
#(
  parameter int IN_W      = TQ_IN_W,
  parameter int OUT_W     = TQ_OUT_W,
  parameter int DEPTH     = 4,
  parameter int INV_SHIFT = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic                    inverse,
  input  logic [1:0]              i_transize,
  input  logic signed [IN_W-1:0]  i_0,  i_1,  i_2,  i_3,  i_4,  i_5,  i_6,  i_7,
  input  logic signed [IN_W-1:0]  i_8,  i_9,  i_10, i_11, i_12, i_13, i_14, i_15,
  input  logic signed [IN_W-1:0]  i_16, i_17, i_18, i_19, i_20, i_21, i_22, i_23,
  input  logic signed [IN_W-1:0]  i_24, i_25, i_26, i_27, i_28, i_29, i_30, i_31,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic signed [OUT_W-1:0] o_0,  o_1,  o_2,  o_3,  o_4,  o_5,  o_6,  o_7,
  output logic signed [OUT_W-1:0] o_8,  o_9,  o_10, o_11, o_12, o_13, o_14, o_15,
  output logic signed [OUT_W-1:0] o_16, o_17, o_18, o_19, o_20, o_21, o_22, o_23,
  output logic signed [OUT_W-1:0] o_24, o_25, o_26, o_27, o_28, o_29, o_30, o_31,
  output logic                    o_first,
  output logic                    o_last,
  output logic [1:0]              o_transize,
  output logic                    o_inverse,
  output logic                    o_almost_full,
  output logic                    o_ovf_err
);

  localparam int AW = $clog2(DEPTH);

  logic signed [IN_W-1:0]  lane_in  [TQ_LANES];
  logic signed [OUT_W-1:0] lane_out [TQ_LANES];

  assign lane_in[0]  = i_0;  assign lane_in[1]  = i_1;  assign lane_in[2]  = i_2;  assign lane_in[3]  = i_3;
  assign lane_in[4]  = i_4;  assign lane_in[5]  = i_5;  assign lane_in[6]  = i_6;  assign lane_in[7]  = i_7;
  assign lane_in[8]  = i_8;  assign lane_in[9]  = i_9;  assign lane_in[10] = i_10; assign lane_in[11] = i_11;
  assign lane_in[12] = i_12; assign lane_in[13] = i_13; assign lane_in[14] = i_14; assign lane_in[15] = i_15;
  assign lane_in[16] = i_16; assign lane_in[17] = i_17; assign lane_in[18] = i_18; assign lane_in[19] = i_19;
  assign lane_in[20] = i_20; assign lane_in[21] = i_21; assign lane_in[22] = i_22; assign lane_in[23] = i_23;
  assign lane_in[24] = i_24; assign lane_in[25] = i_25; assign lane_in[26] = i_26; assign lane_in[27] = i_27;
  assign lane_in[28] = i_28; assign lane_in[29] = i_29; assign lane_in[30] = i_30; assign lane_in[31] = i_31;

  logic [4:0]    row_cnt;
  logic [1:0]    blk_ts;
  logic          blk_inv;
  logic          first_beat;
  logic          last_beat;
  logic [1:0]    eff_ts;
  logic          eff_inv;
  logic [4:0]    shamt;
  tq_entry_t     new_entry;

  // Beat 0 uses the live tags; later beats of the block use the latched ones.
  assign first_beat = (row_cnt == 5'd0);
  assign eff_ts     = first_beat ? i_transize : blk_ts;
  assign eff_inv    = first_beat ? inverse    : blk_inv;
  assign last_beat  = ({1'b0, row_cnt} == (rows_per_block(eff_ts) - 6'd1));
  assign shamt      = eff_inv ? 5'(INV_SHIFT) : fwd_shift(eff_ts);

  for (genvar g = 0; g < TQ_LANES; g++) begin : g_lane
    tq_round_sat #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
    ) u_round_sat (
      .x (lane_in[g]),
      .s (shamt),
      .y (lane_out[g])
    );
  end

  always_comb begin
    new_entry         = '0;
    for (int k = 0; k < TQ_LANES; k++) begin
      new_entry.lanes[k] = lane_out[k];
    end
    new_entry.first   = first_beat;
    new_entry.last    = last_beat;
    new_entry.size    = eff_ts;
    new_entry.inverse = eff_inv;
  end

  tq_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          push;
  logic          pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign o_valid = (count != '0);
  assign pop     = o_valid && o_ready;
  assign push    = i_valid && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // Upstream cannot stall, so row_cnt advances on every beat, dropped or not.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      row_cnt   <= '0;
      blk_ts    <= '0;
      blk_inv   <= 1'b0;
      o_ovf_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (i_valid) begin
        row_cnt <= last_beat ? 5'd0 : row_cnt + 5'd1;
        if (first_beat) begin
          blk_ts  <= i_transize;
          blk_inv <= inverse;
        end
        if (!push) begin
          o_ovf_err <= 1'b1;
        end
      end
    end
  end

  tq_entry_t                         head;
  logic [TQ_LANES-1:0][OUT_W-1:0]    head_lanes;

  // Gating on o_valid keeps the unreset storage from reaching the outputs.
  always_comb begin
    head = o_valid ? mem[rd_ptr] : '0;
    for (int k = 0; k < TQ_LANES; k++) begin
      head_lanes[k] = head.lanes[k];
    end
  end

  assign o_first       = head.first;
  assign o_last        = head.last;
  assign o_transize    = head.size;
  assign o_inverse     = head.inverse;
  assign o_almost_full = (count >= (AW+1)'(DEPTH-1));

  assign o_0  = head_lanes[0];  assign o_1  = head_lanes[1];  assign o_2  = head_lanes[2];  assign o_3  = head_lanes[3];
  assign o_4  = head_lanes[4];  assign o_5  = head_lanes[5];  assign o_6  = head_lanes[6];  assign o_7  = head_lanes[7];
  assign o_8  = head_lanes[8];  assign o_9  = head_lanes[9];  assign o_10 = head_lanes[10]; assign o_11 = head_lanes[11];
  assign o_12 = head_lanes[12]; assign o_13 = head_lanes[13]; assign o_14 = head_lanes[14]; assign o_15 = head_lanes[15];
  assign o_16 = head_lanes[16]; assign o_17 = head_lanes[17]; assign o_18 = head_lanes[18]; assign o_19 = head_lanes[19];
  assign o_20 = head_lanes[20]; assign o_21 = head_lanes[21]; assign o_22 = head_lanes[22]; assign o_23 = head_lanes[23];
  assign o_24 = head_lanes[24]; assign o_25 = head_lanes[25]; assign o_26 = head_lanes[26]; assign o_27 = head_lanes[27];
  assign o_28 = head_lanes[28]; assign o_29 = head_lanes[29]; assign o_30 = head_lanes[30]; assign o_31 = head_lanes[31];

endmodule

// File: tb/tb_tq_stage3_rowpack.sv
// tb/tb_tq_stage3_rowpack.sv - randomized scenario bench with a queue-based reference model
module tb_tq_stage3_rowpack;

  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  logic i_valid;
  logic inverse;
  logic [1:0] i_transize;
  logic o_ready;
  logic signed [27:0] in_lane [32];
  logic signed [15:0] out_lane [32];
  logic o_valid, o_first, o_last, o_inverse, o_almost_full, o_ovf_err;
  logic [1:0] o_transize;
  logic [31:0][15:0] got_lanes;

  typedef struct packed {
    logic [31:0][15:0] lanes;
    logic              first;
    logic              last;
    logic [1:0]        ts;
    logic              inv;
  } exp_t;

  exp_t       mq [$];
  int         m_row;
  int         m_n;
  logic       m_inv;
  logic [1:0] m_ts;
  logic       m_ovf;
  int         vectors;
  int         miscompares;

  tq_stage3_rowpack dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .inverse(inverse), .i_transize(i_transize),
    .i_0(in_lane[0]),   .i_1(in_lane[1]),   .i_2(in_lane[2]),   .i_3(in_lane[3]),
    .i_4(in_lane[4]),   .i_5(in_lane[5]),   .i_6(in_lane[6]),   .i_7(in_lane[7]),
    .i_8(in_lane[8]),   .i_9(in_lane[9]),   .i_10(in_lane[10]), .i_11(in_lane[11]),
    .i_12(in_lane[12]), .i_13(in_lane[13]), .i_14(in_lane[14]), .i_15(in_lane[15]),
    .i_16(in_lane[16]), .i_17(in_lane[17]), .i_18(in_lane[18]), .i_19(in_lane[19]),
    .i_20(in_lane[20]), .i_21(in_lane[21]), .i_22(in_lane[22]), .i_23(in_lane[23]),
    .i_24(in_lane[24]), .i_25(in_lane[25]), .i_26(in_lane[26]), .i_27(in_lane[27]),
    .i_28(in_lane[28]), .i_29(in_lane[29]), .i_30(in_lane[30]), .i_31(in_lane[31]),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_0(out_lane[0]),   .o_1(out_lane[1]),   .o_2(out_lane[2]),   .o_3(out_lane[3]),
    .o_4(out_lane[4]),   .o_5(out_lane[5]),   .o_6(out_lane[6]),   .o_7(out_lane[7]),
    .o_8(out_lane[8]),   .o_9(out_lane[9]),   .o_10(out_lane[10]), .o_11(out_lane[11]),
    .o_12(out_lane[12]), .o_13(out_lane[13]), .o_14(out_lane[14]), .o_15(out_lane[15]),
    .o_16(out_lane[16]), .o_17(out_lane[17]), .o_18(out_lane[18]), .o_19(out_lane[19]),
    .o_20(out_lane[20]), .o_21(out_lane[21]), .o_22(out_lane[22]), .o_23(out_lane[23]),
    .o_24(out_lane[24]), .o_25(out_lane[25]), .o_26(out_lane[26]), .o_27(out_lane[27]),
    .o_28(out_lane[28]), .o_29(out_lane[29]), .o_30(out_lane[30]), .o_31(out_lane[31]),
    .o_first(o_first), .o_last(o_last), .o_transize(o_transize), .o_inverse(o_inverse),
    .o_almost_full(o_almost_full), .o_ovf_err(o_ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    got_lanes = '0;
    for (int k = 0; k < 32; k++) got_lanes[k] = out_lane[k];
  end

  // floor((x + 2^(s-1)) / 2^s), clamped to the 16-bit signed range
  function automatic logic [15:0] ref_round(input longint x, input int s);
    longint v;
    v = (x + (longint'(1) << (s - 1))) >>> s;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return 16'(v);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_row = 0; m_n = 4; m_inv = 1'b0; m_ts = 2'd0; m_ovf = 1'b0;
  endtask

  task automatic rand_lanes();
    for (int k = 0; k < 32; k++) in_lane[k] = 28'($signed($urandom) >>> $urandom_range(4, 16));
  endtask

  // Apply one clock of stimulus, advance the model, then sample 1 ns after the edge.
  task automatic cycle(input logic v, input logic rdy);
    exp_t e;
    bit   pop, push;
    i_valid = v;
    o_ready = rdy;
    e = '0;
    if (rst) begin
      model_reset();
    end else begin
      pop  = (mq.size() > 0) && rdy;
      push = v && ((mq.size() < DEPTH) || pop);
      if (v) begin
        if (m_row == 0) begin
          m_ts = i_transize; m_inv = inverse; m_n = 4 << i_transize;
        end
        e.first = (m_row == 0);
        e.last  = (m_row == m_n - 1);
        e.ts    = m_ts;
        e.inv   = m_inv;
        for (int k = 0; k < 32; k++) e.lanes[k] = ref_round(longint'(in_lane[k]), m_inv ? 7 : int'(m_ts) + 1);
        m_row = (m_row + 1) % m_n;
        if (!push) m_ovf = 1'b1;
      end
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; inverse = 1'b1; i_transize = 2'd3;
    rand_lanes();
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    vectors++;
    if ({o_valid, o_first, o_last, o_transize, o_inverse, o_almost_full, o_ovf_err} !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {o_valid, o_first, o_last, o_transize, o_inverse, o_almost_full, o_ovf_err});
    end
    vectors++;
    if (got_lanes !== '0) begin
      miscompares++;
      $display("FAIL reset_lanes: got o_0=%0d o_31=%0d want 0", out_lane[0], out_lane[31]);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_8x8();
    apply_reset();
    inverse = 1'b0; i_transize = 2'd1;
    rand_lanes();
    in_lane[0] = 28'sd13;
    in_lane[1] = -28'sd13;
    in_lane[2] = 28'sh7FFFFFF;
    in_lane[3] = 28'sh8000000;
    cycle(1'b1, 1'b1);
    vectors++;
    if (o_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %b want 1", o_valid); end
    vectors++;
    if (out_lane[0] !== 16'sd3 || out_lane[1] !== -16'sd3) begin
      miscompares++; $display("FAIL basic_round: got %0d,%0d want 3,-3", out_lane[0], out_lane[1]);
    end
    vectors++;
    if (out_lane[2] !== 16'sd32767 || out_lane[3] !== -16'sd32768) begin
      miscompares++; $display("FAIL basic_sat: got %0d,%0d want 32767,-32768", out_lane[2], out_lane[3]);
    end
    vectors++;
    if (o_first !== 1'b1 || o_last !== 1'b0) begin
      miscompares++; $display("FAIL basic_frame: got first=%b last=%b want 1 0", o_first, o_last);
    end
    vectors++;
    if (mq.size() == 0 || got_lanes !== mq[0].lanes) begin
      miscompares++; $display("FAIL basic_lanes: got %h want model row", got_lanes);
    end
    cycle(1'b0, 1'b1);
    vectors++;
    if (o_valid !== 1'b0) begin miscompares++; $display("FAIL basic_drain: got o_valid=%b want 0", o_valid); end
  endtask

  task automatic test_inv_4x4();
    apply_reset();
    inverse = 1'b1; i_transize = 2'd0;
    for (int r = 0; r < 5; r++) begin
      rand_lanes();
      in_lane[0] = 28'sd64;
      cycle(1'b1, 1'b1);
      vectors++;
      if (o_valid !== 1'b1 || out_lane[0] !== 16'sd1) begin
        miscompares++; $display("FAIL inv_o0 row%0d: got valid=%b o_0=%0d want 1 1", r, o_valid, out_lane[0]);
      end
      vectors++;
      if (o_first !== (r == 0 || r == 4) || o_last !== (r == 3) || o_inverse !== 1'b1) begin
        miscompares++; $display("FAIL inv_frame row%0d: got first=%b last=%b inv=%b", r, o_first, o_last, o_inverse);
      end
      vectors++;
      if (mq.size() == 0 || got_lanes !== mq[0].lanes) begin
        miscompares++; $display("FAIL inv_lanes row%0d: got %h want model row", r, got_lanes);
      end
    end
  endtask

  task automatic test_size_change();
    apply_reset();
    inverse = 1'b0;
    for (int r = 0; r < 17; r++) begin
      i_transize = (r < 5 || r == 16) ? 2'd2 : 2'd0;
      rand_lanes();
      cycle(1'b1, 1'b1);
      vectors++;
      if (o_valid !== 1'b1 || o_transize !== 2'd2 || o_last !== (r == 15) || o_first !== (r == 0 || r == 16)) begin
        miscompares++;
        $display("FAIL size_frame row%0d: got v=%b ts=%0d first=%b last=%b", r, o_valid, o_transize, o_first, o_last);
      end
      vectors++;
      if (mq.size() == 0 || got_lanes !== mq[0].lanes) begin
        miscompares++; $display("FAIL size_lanes row%0d: got %h want model row", r, got_lanes);
      end
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    inverse = 1'b0; i_transize = 2'd1;
    for (int r = 0; r < 5; r++) begin
      rand_lanes();
      cycle(1'b1, 1'b0);
      vectors++;
      if (o_almost_full !== (r >= 2) || o_ovf_err !== (r == 4)) begin
        miscompares++; $display("FAIL ovf_fill row%0d: got af=%b ovf=%b", r, o_almost_full, o_ovf_err);
      end
      vectors++;
      if (mq.size() == 0 || got_lanes !== mq[0].lanes || o_first !== 1'b1) begin
        miscompares++; $display("FAIL ovf_hold row%0d: got first=%b lanes=%h", r, o_first, got_lanes);
      end
    end
    for (int r = 0; r < 8; r++) begin
      if (r >= 4) rand_lanes();
      cycle(r >= 4, 1'b1);
      vectors++;
      if (o_valid !== (mq.size() != 0) || o_ovf_err !== 1'b1) begin
        miscompares++; $display("FAIL ovf_drain step%0d: got v=%b ovf=%b want %b 1", r, o_valid, o_ovf_err, mq.size() != 0);
      end
      if (mq.size() != 0) begin
        vectors++;
        if (got_lanes !== mq[0].lanes || {o_first, o_last, o_transize} !== {mq[0].first, mq[0].last, mq[0].ts}) begin
          miscompares++; $display("FAIL ovf_order step%0d: got first=%b last=%b lanes=%h", r, o_first, o_last, got_lanes);
        end
      end
      if (r >= 4) begin
        vectors++;
        if (o_last !== (r == 6) || o_first !== (r == 7)) begin
          miscompares++; $display("FAIL ovf_realign step%0d: got first=%b last=%b", r, o_first, o_last);
        end
      end
    end
  endtask

  task automatic test_full_stream();
    apply_reset();
    inverse = 1'($urandom_range(0, 1)); i_transize = 2'd3;
    for (int r = 0; r < 4; r++) begin
      rand_lanes();
      cycle(1'b1, 1'b0);
    end
    for (int r = 0; r < 14; r++) begin
      if (r < 10) rand_lanes();
      cycle(r < 10, 1'b1);
      vectors++;
      if (o_valid !== (mq.size() != 0) || o_ovf_err !== 1'b0 || o_almost_full !== (mq.size() >= 3)) begin
        miscompares++;
        $display("FAIL stream_ctrl step%0d: got v=%b ovf=%b af=%b model=%0d", r, o_valid, o_ovf_err, o_almost_full, mq.size());
      end
      if (r < 10) begin
        vectors++;
        if (mq.size() != DEPTH) begin
          miscompares++; $display("FAIL stream_count step%0d: got model=%0d want 4", r, mq.size());
        end
      end
      if (mq.size() != 0) begin
        vectors++;
        if (got_lanes !== mq[0].lanes || {o_first, o_last, o_transize, o_inverse} !== {mq[0].first, mq[0].last, mq[0].ts, mq[0].inv}) begin
          miscompares++; $display("FAIL stream_order step%0d: got first=%b lanes=%h", r, o_first, got_lanes);
        end
      end
    end
  endtask

  task automatic test_rst_mid();
    apply_reset();
    inverse = 1'b0; i_transize = 2'd3;
    for (int r = 0; r < 5; r++) begin
      rand_lanes();
      cycle(1'b1, 1'b0);
    end
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    vectors++;
    if (o_valid !== 1'b1 || o_ovf_err !== 1'b1 || got_lanes !== mq[0].lanes) begin
      miscompares++; $display("FAIL rstmid_pre: got v=%b ovf=%b want 1 1", o_valid, o_ovf_err);
    end
    rst = 1'b1;
    cycle(1'b0, 1'b0);
    rst = 1'b0;
    vectors++;
    if (o_valid !== 1'b0 || o_ovf_err !== 1'b0 || o_almost_full !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_flush: got v=%b ovf=%b af=%b want 0 0 0", o_valid, o_ovf_err, o_almost_full);
    end
    i_transize = 2'd1;
    rand_lanes();
    cycle(1'b1, 1'b1);
    vectors++;
    if (o_valid !== 1'b1 || o_first !== 1'b1 || o_transize !== 2'd1 || got_lanes !== mq[0].lanes) begin
      miscompares++; $display("FAIL rstmid_first: got v=%b first=%b ts=%0d want 1 1 1", o_valid, o_first, o_transize);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b0; inverse = 1'b0; i_transize = 2'd0;
    for (int k = 0; k < 32; k++) in_lane[k] = '0;
    model_reset();
    test_reset();
    test_basic_8x8();
    test_inv_4x4();
    test_size_change();
    test_overflow();
    test_full_stream();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
